// File: rtl/vector_add_sub_nx1_pkg.sv
// Shared Kalman datapath definitions: default sizes, serial-stage FSM states
// and the signed element type used by the nx1 vector stages.
package kalman_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NOS_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic signed [WIDTH_DEF-1:0] elem_t;

    // Index counter width; a single-element vector still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vector_add_sub_nx1_elem_add_sub.sv
// Single-element signed add/sub with overflow detect.
// Build option: SATURATE_EN clamps an overflowing result instead of wrapping.
module elem_add_sub
    import kalman_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] res,
    output logic                    ovf
);

    logic [WIDTH:0] sum_s;

    // Sign-extended add or subtract at WIDTH+1 bits.
    always_comb begin
        sum_s = {(WIDTH+1){1'b0}};
        if (sub) begin
            sum_s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        end else begin
            sum_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        end
    end

    assign ovf = sum_s[WIDTH] ^ sum_s[WIDTH-1];

    // Result selection; the extra sign bit tells which rail was crossed.
    always_comb begin
        res = sum_s[WIDTH-1:0];
`ifdef SATURATE_EN
        if (ovf) begin
            if (sum_s[WIDTH]) begin
                res = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                res = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            res = sum_s[WIDTH-1:0];
        end
`else
        res = sum_s[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/vector_add_sub_nx1.sv
// Serial nx1 vector add/subtract stage chained behind the matrix-vector multiplier.
// Build option: SATURATE_EN (see elem_add_sub) selects clamping instead of wrapping.
module vector_add_sub_nx1
    import kalman_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int nos   = NOS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      startAdd,
    input  logic                      sub,
    input  logic [nos-1:0][WIDTH-1:0] A,
    input  logic [nos-1:0][WIDTH-1:0] B,
    output logic [nos-1:0][WIDTH-1:0] Res,
    output logic                      endAdd,
    output logic                      ovf
);

    localparam int               IDX_W    = idx_width(nos);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(nos - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

    state_t                    state_r;
    logic [IDX_W-1:0]          idx_r;
    logic [nos-1:0][WIDTH-1:0] op_a_r;
    logic [nos-1:0][WIDTH-1:0] op_b_r;
    logic                      sub_r;
    logic [nos-1:0][WIDTH-1:0] res_r;
    logic                      end_r;
    logic                      ovf_r;
    logic signed [WIDTH-1:0]   elem_res_s;
    logic                      elem_ovf_s;

    elem_add_sub #(
        .WIDTH (WIDTH)
    ) u_elem (
        .a   (op_a_r[idx_r]),
        .b   (op_b_r[idx_r]),
        .sub (sub_r),
        .res (elem_res_s),
        .ovf (elem_ovf_s)
    );

    // Sequencer: latch operands at start, write one element per clock, hold done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            op_a_r  <= '0;
            op_b_r  <= '0;
            sub_r   <= 1'b0;
            res_r   <= '0;
            end_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    end_r <= 1'b0;
                    if (startAdd) begin
                        op_a_r  <= A;
                        op_b_r  <= B;
                        sub_r   <= sub;
                        ovf_r   <= 1'b0;
                        idx_r   <= '0;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    res_r[idx_r] <= elem_res_s;
                    if (elem_ovf_s) begin
                        ovf_r <= 1'b1;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                DONE: begin
                    // endAdd trails entry to DONE by one edge and stays up while start is held.
                    end_r <= 1'b1;
                    if (!startAdd) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    end_r   <= 1'b0;
                end
            endcase
        end
    end

    assign Res    = res_r;
    assign endAdd = end_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_vector_add_sub_nx1.sv
// Self-checking bench for vector_add_sub_nx1: transaction-level model plus literal checks.
// Honours SATURATE_EN the same way as the RTL build.
module tb_vector_add_sub_nx1;

    localparam int W = 16;
    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  startAdd;
    logic                  sub;
    logic [N-1:0][W-1:0]   A;
    logic [N-1:0][W-1:0]   B;
    logic [N-1:0][W-1:0]   Res;
    logic                  endAdd;
    logic                  ovf;

    int checks   = 0;
    int failures = 0;

    // Model state: cycles since the start-sampling edge (-1 when idle).
    int           m_t;
    logic [W-1:0] m_res  [N];
    logic [W-1:0] m_exp  [N];
    bit           m_eovf [N];
    bit           m_end;
    bit           m_ovf;

    always #5 clk = ~clk;

    vector_add_sub_nx1 #(.WIDTH(W), .nos(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .startAdd (startAdd),
        .sub      (sub),
        .A        (A),
        .B        (B),
        .Res      (Res),
        .endAdd   (endAdd),
        .ovf      (ovf)
    );

    function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                 output logic [W-1:0] r, output bit o);
        int full;
        full = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        o = (full > 32767) || (full < -32768);
        r = full[W-1:0];
`ifdef SATURATE_EN
        if (o) r = (full > 0) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by the edge that just happened, using the inputs it sampled.
    task automatic model_step();
        if (rst) begin
            m_t = -1; m_end = 0; m_ovf = 0;
            for (int i = 0; i < N; i++) m_res[i] = '0;
        end else if (m_t < 0) begin
            m_end = 0;
            if (startAdd) begin
                for (int i = 0; i < N; i++) calc(A[i], B[i], sub, m_exp[i], m_eovf[i]);
                m_t = 0; m_ovf = 0;
            end
        end else begin
            m_t++;
            if (m_t <= N) begin
                m_res[m_t-1] = m_exp[m_t-1];
                if (m_eovf[m_t-1]) m_ovf = 1;
            end else begin
                m_end = 1;
                if (!startAdd) m_t = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        for (int i = 0; i < N; i++) chk($sformatf("res%0d", i), 32'(Res[i]), 32'(m_res[i]));
        chk("endAdd", 32'(endAdd), 32'(m_end));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic run_op(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b,
                          input logic s, input int hold, input bit scramble,
                          output int rise, output int highs);
        bit done;
        A = a; B = b; sub = s; startAdd = 1'b1;
        rise = -1; highs = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (endAdd) begin
                if (rise < 0) rise = k;
                highs++;
            end
            if (k == 0 && scramble) begin
                A = ~a; B = {N{16'h1234}}; sub = ~s;
            end
            if (k + 1 >= hold) startAdd = 1'b0;
            if (k + 1 >= hold && m_t < 0 && !m_end) done = 1;
        end
        chk("op_completes", 32'(done), 32'd1);
    endtask

    initial begin
        int rise, highs;
        logic [N-1:0][W-1:0] va, vb;

        rst = 1'b1; startAdd = 1'b0; sub = 1'b0; A = '0; B = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_end", 32'(endAdd), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_res0", 32'(Res[0]), 32'd0);
        tick();

        // 1: chain from multiplier, add
        va = {16'd104, 16'd62, 16'd78, 16'd129};
        vb = {16'd4, 16'd3, 16'd2, 16'd1};
        run_op(va, vb, 1'b0, 5, 1'b0, rise, highs);
        chk("t1_res0", 32'(Res[0]), 32'd130);
        chk("t1_res1", 32'(Res[1]), 32'd80);
        chk("t1_res2", 32'(Res[2]), 32'd65);
        chk("t1_res3", 32'(Res[3]), 32'd108);
        chk("t1_ovf", 32'(ovf), 32'd0);
        chk("t1_rise", 32'(rise), 32'd5);
        chk("t1_highs", 32'(highs), 32'd1);

        // 2: subtract
        vb = {16'd100, 16'd60, 16'd80, 16'd130};
        run_op(va, vb, 1'b1, 1, 1'b0, rise, highs);
        chk("t2_res0", 32'(Res[0]), 32'h0000FFFF);
        chk("t2_res1", 32'(Res[1]), 32'h0000FFFE);
        chk("t2_res2", 32'(Res[2]), 32'd2);
        chk("t2_res3", 32'(Res[3]), 32'd4);
        chk("t2_ovf", 32'(ovf), 32'd0);

        // 3a: positive overflow on element 0
        va = {16'd0, 16'd0, 16'd0, 16'h7FFF};
        vb = {16'd0, 16'd0, 16'd0, 16'd1};
        run_op(va, vb, 1'b0, 1, 1'b0, rise, highs);
        chk("t3a_ovf", 32'(ovf), 32'd1);
`ifdef SATURATE_EN
        chk("t3a_res0", 32'(Res[0]), 32'h7FFF);
`else
        chk("t3a_res0", 32'(Res[0]), 32'h8000);
`endif

        // 3b: negative overflow on element 1
        va = {16'd0, 16'd0, 16'h8000, 16'd0};
        vb = {16'd0, 16'd0, 16'd1, 16'd0};
        run_op(va, vb, 1'b1, 1, 1'b0, rise, highs);
        chk("t3b_ovf", 32'(ovf), 32'd1);
`ifdef SATURATE_EN
        chk("t3b_res1", 32'(Res[1]), 32'h8000);
`else
        chk("t3b_res1", 32'(Res[1]), 32'h7FFF);
`endif

        // 4: operands change during RUN, start held long
        va = {16'd40, 16'd30, 16'd20, 16'd10};
        vb = {16'd4, 16'd3, 16'd2, 16'd1};
        run_op(va, vb, 1'b1, 8, 1'b1, rise, highs);
        chk("t4_res0", 32'(Res[0]), 32'd9);
        chk("t4_res3", 32'(Res[3]), 32'd36);
        chk("t4_ovf", 32'(ovf), 32'd0);
        chk("t4_rise", 32'(rise), 32'd5);
        chk("t4_highs", 32'(highs), 32'd4);

        // 5: reset on the second RUN cycle
        A = {16'd5, 16'd5, 16'd5, 16'd5}; B = A; sub = 1'b0; startAdd = 1'b1;
        tick();
        startAdd = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_res0", 32'(Res[0]), 32'd0);
        chk("t5_res3", 32'(Res[3]), 32'd0);
        chk("t5_end", 32'(endAdd), 32'd0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        va = {16'd104, 16'd62, 16'd78, 16'd129};
        vb = {16'd100, 16'd60, 16'd80, 16'd130};
        run_op(va, vb, 1'b1, 1, 1'b0, rise, highs);
        chk("t5_res0_after", 32'(Res[0]), 32'h0000FFFF);
        chk("t5_rise", 32'(rise), 32'd5);

        // 6: one-cycle start pulse, edge-of-range result without overflow
        va = {16'h7FFE, 16'd7, 16'hFFFB, 16'd1000};
        vb = {16'd1, 16'd9, 16'd5, 16'd24};
        run_op(va, vb, 1'b0, 1, 1'b0, rise, highs);
        chk("t6_res0", 32'(Res[0]), 32'd1024);
        chk("t6_res1", 32'(Res[1]), 32'd0);
        chk("t6_res2", 32'(Res[2]), 32'd16);
        chk("t6_res3", 32'(Res[3]), 32'h7FFF);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_highs", 32'(highs), 32'd1);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
